player_move_ctrl: RTL and testbench

PLAYER_MOVE_CTRL -- requirements
Module: player_move_ctrl

---
 rtl/player_move_ctrl.sv | 164 ++++++++++++++++
 tb/tb_player_move_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/player_move_ctrl.sv
// rtl/player_move_ctrl.sv - two-requester arbitrated player position controller
//
// Three-state controller (IDLE -> MOVE -> WAIT) that moves a player one pixel
// per axis per step, arbitrating between two direction requesters.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   src_a_req   requester A (buttons) wants a move
//   src_a_dir   A direction {up,down,left,right}
//   src_b_req   requester B (demo/AI) wants a move
//   src_b_dir   B direction {up,down,left,right}
//   cfg_load    teleport strobe; loads clamped cfg_x/cfg_y
//   cfg_x/cfg_y teleport coordinates
//   grant_a/b   one-cycle pulse when that source's direction is latched
//   player_x/y  current position, unsigned
//   move_pulse  one-cycle pulse when a move changed the position
module player_move_ctrl #(
    parameter int INIT_X   = 10,
    parameter int INIT_Y   = 10,
    parameter int X_MAX    = 639,
    parameter int Y_MAX    = 479,
    parameter int STEP_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       src_a_req,
    input  logic [3:0] src_a_dir,
    input  logic       src_b_req,
    input  logic [3:0] src_b_dir,
    input  logic       cfg_load,
    input  logic [9:0] cfg_x,
    input  logic [9:0] cfg_y,
    output logic       grant_a,
    output logic       grant_b,
    output logic [9:0] player_x,
    output logic [9:0] player_y,
    output logic       move_pulse
);

    localparam logic [9:0] X_LIM    = 10'(X_MAX);
    localparam logic [9:0] Y_LIM    = 10'(Y_MAX);
    localparam logic [9:0] X_START  = 10'(INIT_X);
    localparam logic [9:0] Y_START  = 10'(INIT_Y);
    localparam logic [7:0] CNT_LAST = 8'(STEP_DIV - 1);

    typedef enum logic [1:0] {IDLE, MOVE, WAIT} state_t;

    state_t     state_q, state_d;
    logic [3:0] dir_q, dir_d;
    logic [7:0] cnt_q, cnt_d;
    logic       last_b_q, last_b_d;     // 1: B was granted most recently
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       grant_a_q, grant_a_d;
    logic       grant_b_q, grant_b_d;
    logic       pulse_q, pulse_d;
    logic [9:0] mx, my;
    logic       pick_a;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        last_b_d  = last_b_q;
        x_d       = x_q;
        y_d       = y_q;
        grant_a_d = 1'b0;
        grant_b_d = 1'b0;
        pulse_d   = 1'b0;
        pick_a    = 1'b0;

        // Saturating step; opposing bits on one axis cancel.
        // dir = {up, down, left, right}
        mx = x_q;
        if (dir_q[0] && !dir_q[1] && x_q < X_LIM)
            mx = x_q + 10'd1;
        else if (dir_q[1] && !dir_q[0] && x_q != 10'd0)
            mx = x_q - 10'd1;

        my = y_q;
        if (dir_q[3] && !dir_q[2] && y_q < Y_LIM)
            my = y_q + 10'd1;
        else if (dir_q[2] && !dir_q[3] && y_q != 10'd0)
            my = y_q - 10'd1;

        case (state_q)
            IDLE: begin
                if (src_a_req || src_b_req) begin
                    // On a tie the source not granted last time wins.
                    pick_a = src_a_req && (!src_b_req || last_b_q);
                    if (pick_a) begin
                        grant_a_d = 1'b1;
                        dir_d     = src_a_dir;
                        last_b_d  = 1'b0;
                    end else begin
                        grant_b_d = 1'b1;
                        dir_d     = src_b_dir;
                        last_b_d  = 1'b1;
                    end
                    state_d = MOVE;
                end
            end
            MOVE: begin
                x_d     = mx;
                y_d     = my;
                pulse_d = (mx != x_q) || (my != y_q);
                cnt_d   = 8'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == CNT_LAST)
                    state_d = IDLE;
                else
                    cnt_d = cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase

        // Teleport overrides any same-cycle grant or move.
        if (cfg_load) begin
            x_d       = (cfg_x > X_LIM) ? X_LIM : cfg_x;
            y_d       = (cfg_y > Y_LIM) ? Y_LIM : cfg_y;
            grant_a_d = 1'b0;
            grant_b_d = 1'b0;
            pulse_d   = 1'b0;
            dir_d     = dir_q;
            last_b_d  = last_b_q;
            cnt_d     = 8'd0;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            dir_q     <= 4'd0;
            cnt_q     <= 8'd0;
            last_b_q  <= 1'b1;
            x_q       <= X_START;
            y_q       <= Y_START;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            last_b_q  <= last_b_d;
            x_q       <= x_d;
            y_q       <= y_d;
            grant_a_q <= grant_a_d;
            grant_b_q <= grant_b_d;
            pulse_q   <= pulse_d;
        end
    end

    assign grant_a    = grant_a_q;
    assign grant_b    = grant_b_q;
    assign player_x   = x_q;
    assign player_y   = y_q;
    assign move_pulse = pulse_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// tb/tb_player_move_ctrl.sv - directed self-checking bench for player_move_ctrl
module tb_player_move_ctrl;

    localparam int STEP_DIV = 4;

    logic       clk;
    logic       reset;
    logic       src_a_req;
    logic [3:0] src_a_dir;
    logic       src_b_req;
    logic [3:0] src_b_dir;
    logic       cfg_load;
    logic [9:0] cfg_x;
    logic [9:0] cfg_y;
    logic       grant_a;
    logic       grant_b;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic       move_pulse;

    int n_checks = 0;
    int n_errors = 0;

    player_move_ctrl #(
        .INIT_X(10), .INIT_Y(10), .X_MAX(639), .Y_MAX(479), .STEP_DIV(STEP_DIV)
    ) dut (
        .clk(clk), .reset(reset),
        .src_a_req(src_a_req), .src_a_dir(src_a_dir),
        .src_b_req(src_b_req), .src_b_dir(src_b_dir),
        .cfg_load(cfg_load), .cfg_x(cfg_x), .cfg_y(cfg_y),
        .grant_a(grant_a), .grant_b(grant_b),
        .player_x(player_x), .player_y(player_y),
        .move_pulse(move_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_state(input string tag, input int x, input int y,
                               input int ga, input int gb, input int mp);
        check({tag, ".x"}, int'(player_x), x);
        check({tag, ".y"}, int'(player_y), y);
        check({tag, ".ga"}, int'(grant_a), ga);
        check({tag, ".gb"}, int'(grant_b), gb);
        check({tag, ".mp"}, int'(move_pulse), mp);
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        #1;
        check_state("rst", 10, 10, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Single A request, released once granted; checks grant and resulting move.
    task automatic move_a(input string tag, input logic [3:0] dir,
                          input int x, input int y, input int mp);
        src_a_req = 1'b1;
        src_a_dir = dir;
        step();
        check({tag, ".grant"}, int'(grant_a), 1);
        src_a_req = 1'b0;
        step();
        check_state(tag, x, y, 0, 0, mp);
        repeat (STEP_DIV) step();
    endtask

    task automatic teleport(input string tag, input int cx, input int cy,
                            input int x, input int y);
        cfg_load = 1'b1;
        cfg_x    = 10'(cx);
        cfg_y    = 10'(cy);
        step();
        cfg_load = 1'b0;
        check_state(tag, x, y, 0, 0, 0);
    endtask

    initial begin
        reset     = 1'b1;
        src_a_req = 1'b0;
        src_a_dir = 4'd0;
        src_b_req = 1'b0;
        src_b_dir = 4'd0;
        cfg_load  = 1'b0;
        cfg_x     = 10'd0;
        cfg_y     = 10'd0;
        #1;
        reset_pulse();

        // A right, held: grant after 1 edge, move after 2, next move STEP_DIV+2 later
        src_a_req = 1'b1;
        src_a_dir = 4'b0001;
        step();
        check_state("a1.grant", 10, 10, 1, 0, 0);
        step();
        check_state("a1.move", 11, 10, 0, 0, 1);
        for (int i = 0; i < STEP_DIV; i++) begin
            step();
            check_state("a1.wait", 11, 10, 0, 0, 0);
        end
        step();
        check_state("a2.grant", 11, 10, 1, 0, 0);
        step();
        check_state("a2.move", 12, 10, 0, 0, 1);
        src_a_req = 1'b0;
        repeat (STEP_DIV) step();

        // Round-robin tie: A up, B down, A wins first after reset
        reset_pulse();
        src_a_req = 1'b1;
        src_a_dir = 4'b1000;
        src_b_req = 1'b1;
        src_b_dir = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr.ga", int'(grant_a), (i % 2 == 0) ? 1 : 0);
            check("rr.gb", int'(grant_b), (i % 2 == 1) ? 1 : 0);
            step();
            check("rr.y", int'(player_y), (i % 2 == 0) ? 11 : 10);
            check("rr.mp", int'(move_pulse), 1);
            repeat (STEP_DIV) step();
        end
        src_a_req = 1'b0;
        src_b_req = 1'b0;

        // Teleport beyond max clamps; up+right at the corner is fully clamped
        teleport("tp.max", 1000, 1000, 639, 479);
        move_a("corner", 4'b1001, 639, 479, 0);

        // Origin: down+left clamps, up+down cancels, up+right moves both axes
        teleport("tp.zero", 0, 0, 0, 0);
        move_a("dl0", 4'b0110, 0, 0, 0);
        move_a("ud0", 4'b1100, 0, 0, 0);
        move_a("diag", 4'b1001, 1, 1, 1);

        // B alone wins, moves left
        src_b_req = 1'b1;
        src_b_dir = 4'b0010;
        step();
        check_state("b.grant", 1, 1, 0, 1, 0);
        src_b_req = 1'b0;
        step();
        check_state("b.move", 0, 1, 0, 0, 1);
        repeat (STEP_DIV) step();

        // Reset asserted during WAIT aborts and restores start position at once
        src_a_req = 1'b1;
        src_a_dir = 4'b0001;
        step();
        src_a_req = 1'b0;
        step();
        check("w.move.x", int'(player_x), 1);
        step();
        reset_pulse();

        // cfg_load in the MOVE cycle wins over the move
        src_a_req = 1'b1;
        src_a_dir = 4'b0001;
        step();
        check("cm.grant", int'(grant_a), 1);
        src_a_req = 1'b0;
        teleport("cm.load", 100, 200, 100, 200);
        step();
        check_state("cm.after", 100, 200, 0, 0, 0);

        // cfg_load in the same cycle as a grant suppresses the grant
        src_a_req = 1'b1;
        src_a_dir = 4'b0001;
        teleport("cg.load", 5, 6, 5, 6);
        step();
        check_state("cg.grant", 5, 6, 1, 0, 0);
        src_a_req = 1'b0;
        step();
        check_state("cg.move", 6, 6, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
